// File: rtl/decode_stage.sv
// Purpose: RV32I decode stage; drives the register-file read port and registers decoded fields for execute.
// Latency: 1 cycle from accept to o_ex_valid, aligned with the register file's 1-cycle read data.
// Backpressure: o_if_ready drops while execute stalls a full output slot or a RAW hazard is pending.
//
// Ports:
//   clk, rst                      - single clock, asynchronous active-high reset
//   i_if_valid/o_if_ready         - fetch handshake; i_if_instr, i_if_pc carry the instruction
//   o_rs_ren, o_rs1/2_raddr       - register file read request (addresses combinational from i_if_instr)
//   o_ex_valid/i_ex_ready         - execute handshake; o_ex_* are the registered decoded fields
//   i_wb_valid, i_wb_addr         - writeback retire, clears the scoreboard busy bit
//
// Build option: define DECODE_SCOREBOARD_EN to enable the busy scoreboard and RAW hazard stall.
// Without it the hazard is tied off and hazard avoidance is left to the surrounding pipeline.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_rs_ren,
    output logic [4:0]      o_rs1_raddr,
    output logic [4:0]      o_rs2_raddr,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [6:0]      o_ex_opcode,
    output logic [2:0]      o_ex_funct3,
    output logic [6:0]      o_ex_funct7,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_rd_we,
    output logic [XLEN-1:0] o_ex_imm,
    output logic            o_ex_illegal,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_addr
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ------------------------------------------------------------------
    // Field extraction and immediate formats
    // ------------------------------------------------------------------
    logic [6:0] dec_opcode;
    logic [4:0] dec_rd;
    logic [2:0] dec_funct3;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [6:0] dec_funct7;

    assign dec_opcode = i_if_instr[6:0];
    assign dec_rd     = i_if_instr[11:7];
    assign dec_funct3 = i_if_instr[14:12];
    assign dec_rs1    = i_if_instr[19:15];
    assign dec_rs2    = i_if_instr[24:20];
    assign dec_funct7 = i_if_instr[31:25];

    assign o_rs1_raddr = dec_rs1;
    assign o_rs2_raddr = dec_rs2;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-11){i_if_instr[31]}}, i_if_instr[30:20]};
    assign imm_s = {{(XLEN-11){i_if_instr[31]}}, i_if_instr[30:25], i_if_instr[11:7]};
    assign imm_b = {{(XLEN-12){i_if_instr[31]}}, i_if_instr[7], i_if_instr[30:25],
                    i_if_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){i_if_instr[31]}}, i_if_instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){i_if_instr[31]}}, i_if_instr[19:12], i_if_instr[20],
                    i_if_instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    logic            dec_legal;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_writes;
    logic [XLEN-1:0] dec_imm;
    logic            dec_rd_we;

    always_comb begin
        dec_legal = 1'b0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        rd_writes = 1'b0;
        dec_imm   = '0;
        case (dec_opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_legal = 1'b1;
                rd_writes = 1'b1;
                dec_imm   = imm_u;
            end
            OPC_JAL: begin
                dec_legal = 1'b1;
                rd_writes = 1'b1;
                dec_imm   = imm_j;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                dec_legal = 1'b1;
                rs1_used  = 1'b1;
                rd_writes = 1'b1;
                dec_imm   = imm_i;
            end
            OPC_BRANCH: begin
                dec_legal = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                dec_imm   = imm_b;
            end
            OPC_STORE: begin
                dec_legal = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                dec_imm   = imm_s;
            end
            OPC_OP: begin
                dec_legal = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                rd_writes = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                dec_legal = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // x0 is never a real destination, so it must not set a busy bit either.
    assign dec_rd_we = rd_writes && (dec_rd != 5'd0);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic hazard;
    logic accept;
    logic ex_valid_q, ex_valid_d;

    assign o_if_ready = (!ex_valid_q || i_ex_ready) && !hazard;
    assign accept     = i_if_valid && o_if_ready;
    assign o_rs_ren   = accept;

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (i_wb_valid) begin
            busy_d[i_wb_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle set of the same register wins.
        if (accept && dec_rd_we) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Uses the registered bits: a register retiring this cycle is not yet
    // visible in the register file read, so it must still stall.
    assign hazard = i_if_valid && ((rs1_used && busy_q[dec_rs1]) ||
                                   (rs2_used && busy_q[dec_rs2]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign unused_wb = ^{i_wb_valid, i_wb_addr, rs1_used, rs2_used};
`endif

    // ------------------------------------------------------------------
    // Output register to execute
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [6:0]      ex_opcode_q, ex_opcode_d;
    logic [2:0]      ex_funct3_q, ex_funct3_d;
    logic [6:0]      ex_funct7_q, ex_funct7_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_rd_we_q, ex_rd_we_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic            ex_illegal_q, ex_illegal_d;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_opcode_d  = ex_opcode_q;
        ex_funct3_d  = ex_funct3_q;
        ex_funct7_d  = ex_funct7_q;
        ex_rd_d      = ex_rd_q;
        ex_rd_we_d   = ex_rd_we_q;
        ex_imm_d     = ex_imm_q;
        ex_illegal_d = ex_illegal_q;
        if (accept) begin
            ex_valid_d   = 1'b1;
            ex_pc_d      = i_if_pc;
            ex_opcode_d  = dec_opcode;
            ex_funct3_d  = dec_funct3;
            ex_funct7_d  = dec_funct7;
            ex_rd_d      = dec_rd;
            ex_rd_we_d   = dec_rd_we;
            ex_imm_d     = dec_imm;
            ex_illegal_d = !dec_legal;
        end else if (i_ex_ready) begin
            // Slot drained with nothing new behind it; fields keep their last value.
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_opcode_q  <= '0;
            ex_funct3_q  <= '0;
            ex_funct7_q  <= '0;
            ex_rd_q      <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_imm_q     <= '0;
            ex_illegal_q <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_funct3_q  <= ex_funct3_d;
            ex_funct7_q  <= ex_funct7_d;
            ex_rd_q      <= ex_rd_d;
            ex_rd_we_q   <= ex_rd_we_d;
            ex_imm_q     <= ex_imm_d;
            ex_illegal_q <= ex_illegal_d;
        end
    end

    assign o_ex_valid   = ex_valid_q;
    assign o_ex_pc      = ex_pc_q;
    assign o_ex_opcode  = ex_opcode_q;
    assign o_ex_funct3  = ex_funct3_q;
    assign o_ex_funct7  = ex_funct7_q;
    assign o_ex_rd      = ex_rd_q;
    assign o_ex_rd_we   = ex_rd_we_q;
    assign o_ex_imm     = ex_imm_q;
    assign o_ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by a randomized run
// checked cycle by cycle against a transaction-level reference model.
// Expectations follow DECODE_SCOREBOARD_EN the same way the design does.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        i_if_valid;
    logic        o_if_ready;
    logic [31:0] i_if_instr;
    logic [31:0] i_if_pc;
    logic        o_rs_ren;
    logic [4:0]  o_rs1_raddr;
    logic [4:0]  o_rs2_raddr;
    logic        o_ex_valid;
    logic        i_ex_ready;
    logic [31:0] o_ex_pc;
    logic [6:0]  o_ex_opcode;
    logic [2:0]  o_ex_funct3;
    logic [6:0]  o_ex_funct7;
    logic [4:0]  o_ex_rd;
    logic        o_ex_rd_we;
    logic [31:0] o_ex_imm;
    logic        o_ex_illegal;
    logic        i_wb_valid;
    logic [4:0]  i_wb_addr;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic        illegal;
    } ex_t;

    decode_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_if_valid   (i_if_valid),
        .o_if_ready   (o_if_ready),
        .i_if_instr   (i_if_instr),
        .i_if_pc      (i_if_pc),
        .o_rs_ren     (o_rs_ren),
        .o_rs1_raddr  (o_rs1_raddr),
        .o_rs2_raddr  (o_rs2_raddr),
        .o_ex_valid   (o_ex_valid),
        .i_ex_ready   (i_ex_ready),
        .o_ex_pc      (o_ex_pc),
        .o_ex_opcode  (o_ex_opcode),
        .o_ex_funct3  (o_ex_funct3),
        .o_ex_funct7  (o_ex_funct7),
        .o_ex_rd      (o_ex_rd),
        .o_ex_rd_we   (o_ex_rd_we),
        .o_ex_imm     (o_ex_imm),
        .o_ex_illegal (o_ex_illegal),
        .i_wb_valid   (i_wb_valid),
        .i_wb_addr    (i_wb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DECODE_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    localparam logic [31:0] I_ADDI_X5  = 32'hFFF00293; // addi x5,x0,-1
    localparam logic [31:0] I_BEQ      = 32'hFE208EE3; // beq x1,x2,-4
    localparam logic [31:0] I_ADD_655  = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] I_LUI_X7   = 32'h123453B7; // lui x7,0x12345
    localparam logic [31:0] I_ILL_RD5  = 32'h000002FF; // opcode 0x7F, rd=5
    localparam logic [31:0] I_ADDI_X0  = 32'h00100013; // addi x0,x0,1
    localparam logic [31:0] I_ADD_600  = 32'h00000333; // add x6,x0,x0

    // ---------------- reference model ----------------
    function automatic bit uses_rs1(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    endfunction

    function automatic bit uses_rs2(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return op inside {7'h63, 7'h23, 7'h33};
    endfunction

    function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        ex_t e;
        logic signed [31:0] s;
        logic [6:0] op;
        bit writes;
        s = ins;
        op = ins[6:0];
        writes = 1'b0;
        e.pc = pc;
        e.opcode = op;
        e.f3 = ins[14:12];
        e.f7 = ins[31:25];
        e.rd = ins[11:7];
        e.imm = 32'd0;
        e.illegal = 1'b0;
        case (op)
            7'h37, 7'h17: begin
                writes = 1'b1;
                e.imm = ins & 32'hFFFFF000;
            end
            7'h6F: begin
                writes = 1'b1;
                e.imm = 32'((s >>> 31) << 20) | (32'(ins[19:12]) << 12)
                      | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'h67, 7'h03, 7'h13: begin
                writes = 1'b1;
                e.imm = 32'(s >>> 20);
            end
            7'h63: begin
                e.imm = 32'((s >>> 31) << 12) | (32'(ins[7]) << 11)
                      | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'h23: begin
                e.imm = (32'(s >>> 20) & ~32'h1F) | 32'(ins[11:7]);
            end
            7'h33: writes = 1'b1;
            7'h0F, 7'h73: writes = 1'b0;
            default: e.illegal = 1'b1;
        endcase
        e.rd_we = writes && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic ex_t dut_ex();
        return {o_ex_pc, o_ex_opcode, o_ex_funct3, o_ex_funct7, o_ex_rd,
                o_ex_rd_we, o_ex_imm, o_ex_illegal};
    endfunction

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        i_if_valid = 1'b0;
        i_if_instr = 32'h0;
        i_if_pc    = 32'h0;
        i_ex_ready = 1'b1;
        i_wb_valid = 1'b0;
        i_wb_addr  = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive point: 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        i_if_valid = 1'b1;
        i_if_instr = ins;
        i_if_pc    = pc;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        tests_run++;
        if (o_ex_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b want 0", o_ex_valid);
        end
        tests_run++;
        if (dut_ex() !== '0) begin
            tests_failed++;
            $display("FAIL reset_fields: got %h want 0", dut_ex());
        end
        next_cycle();
        rst = 1'b0;
        #1;
        tests_run++;
        if (o_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", o_if_ready);
        end
    endtask

    task automatic test_addi();
        ex_t exp;
        do_reset();
        next_cycle();
        present(I_ADDI_X5, 32'h100);
        #1;
        tests_run++;
        if (o_rs_ren !== 1'b1 || o_rs1_raddr !== 5'd0) begin
            tests_failed++;
            $display("FAIL addi_read: ren=%b rs1=%0d want ren=1 rs1=0", o_rs_ren, o_rs1_raddr);
        end
        next_cycle();
        idle_inputs();
        #1;
        exp = '{pc:32'h100, opcode:7'h13, f3:3'd0, f7:7'h7F, rd:5'd5, rd_we:1'b1,
                imm:32'hFFFFFFFF, illegal:1'b0};
        tests_run++;
        if (o_ex_valid !== 1'b1 || dut_ex() !== exp) begin
            tests_failed++;
            $display("FAIL addi_decode: valid=%b got %h want %h", o_ex_valid, dut_ex(), exp);
        end
        tests_run++;
        if (o_rs_ren !== 1'b0) begin
            tests_failed++;
            $display("FAIL addi_ren_pulse: got %b want 0", o_rs_ren);
        end
        next_cycle();
        tests_run++;
        if (o_ex_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL addi_drain: got %b want 0", o_ex_valid);
        end
    endtask

    task automatic test_branch();
        do_reset();
        next_cycle();
        present(I_BEQ, 32'h200);
        #1;
        tests_run++;
        if (o_rs1_raddr !== 5'd1 || o_rs2_raddr !== 5'd2) begin
            tests_failed++;
            $display("FAIL beq_raddr: rs1=%0d rs2=%0d want 1 2", o_rs1_raddr, o_rs2_raddr);
        end
        next_cycle();
        idle_inputs();
        #1;
        tests_run++;
        if (o_ex_imm !== 32'hFFFFFFFC || o_ex_rd_we !== 1'b0 || o_ex_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL beq_decode: imm=%h rd_we=%b valid=%b want fffffffc 0 1",
                     o_ex_imm, o_ex_rd_we, o_ex_valid);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        next_cycle();
        present(I_ADDI_X5, 32'h300);
        next_cycle();
        present(I_ADD_655, 32'h304);
        #1;
        if (SB_EN) begin
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (o_if_ready !== 1'b0 || o_rs_ren !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL hazard_stall%0d: ready=%b ren=%b want 0 0", k, o_if_ready, o_rs_ren);
                end
                next_cycle();
            end
            i_wb_valid = 1'b1;
            i_wb_addr  = 5'd5;
            #1;
            tests_run++;
            if (o_if_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hazard_wb_same_cycle: ready=%b want 0", o_if_ready);
            end
            next_cycle();
            i_wb_valid = 1'b0;
            #1;
        end
        tests_run++;
        if (o_if_ready !== 1'b1 || o_rs_ren !== 1'b1) begin
            tests_failed++;
            $display("FAIL hazard_release: ready=%b ren=%b want 1 1", o_if_ready, o_rs_ren);
        end
        next_cycle();
        idle_inputs();
        #1;
        tests_run++;
        if (o_ex_valid !== 1'b1 || o_ex_rd !== 5'd6 || o_ex_pc !== 32'h304) begin
            tests_failed++;
            $display("FAIL hazard_add_out: valid=%b rd=%0d pc=%h want 1 6 304",
                     o_ex_valid, o_ex_rd, o_ex_pc);
        end
    endtask

    task automatic test_backpressure();
        ex_t exp_addi, exp_lui;
        exp_addi = model_decode(I_ADDI_X5, 32'h400);
        exp_lui  = model_decode(I_LUI_X7, 32'h404);
        do_reset();
        next_cycle();
        present(I_ADDI_X5, 32'h400);
        next_cycle();
        present(I_LUI_X7, 32'h404);
        i_ex_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_ex_valid !== 1'b1 || dut_ex() !== exp_addi ||
                o_if_ready !== 1'b0 || o_rs_ren !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: valid=%b ex=%h ready=%b ren=%b want 1 %h 0 0",
                         k, o_ex_valid, dut_ex(), o_if_ready, o_rs_ren, exp_addi);
            end
            next_cycle();
            #1;
        end
        i_ex_ready = 1'b1;
        #1;
        tests_run++;
        if (o_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_resume_ready: got %b want 1", o_if_ready);
        end
        next_cycle();
        idle_inputs();
        #1;
        tests_run++;
        if (o_ex_valid !== 1'b1 || dut_ex() !== exp_lui) begin
            tests_failed++;
            $display("FAIL bp_lui: got %h want %h", dut_ex(), exp_lui);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        next_cycle();
        present(I_ILL_RD5, 32'h500);
        next_cycle();
        present(I_ADD_655, 32'h504);
        #1;
        tests_run++;
        if (o_ex_illegal !== 1'b1 || o_ex_rd_we !== 1'b0 || o_ex_imm !== 32'h0) begin
            tests_failed++;
            $display("FAIL illegal_decode: ill=%b rd_we=%b imm=%h want 1 0 0",
                     o_ex_illegal, o_ex_rd_we, o_ex_imm);
        end
        tests_run++;
        if (o_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_no_busy: ready=%b want 1", o_if_ready);
        end
        next_cycle();
        present(I_ADDI_X0, 32'h508);
        next_cycle();
        present(I_ADD_600, 32'h50C);
        #1;
        tests_run++;
        if (o_ex_rd_we !== 1'b0 || o_ex_rd !== 5'd0 || o_ex_illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd0_decode: rd_we=%b rd=%0d ill=%b want 0 0 0",
                     o_ex_rd_we, o_ex_rd, o_ex_illegal);
        end
        tests_run++;
        if (o_if_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd0_no_busy: ready=%b want 1", o_if_ready);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        ex_t exp_add;
        exp_add = model_decode(I_ADD_655, 32'h604);
        do_reset();
        next_cycle();
        present(I_ADDI_X5, 32'h600);
        next_cycle();
        idle_inputs();
        i_ex_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (o_ex_valid !== 1'b0 || dut_ex() !== '0) begin
            tests_failed++;
            $display("FAIL rst_async: valid=%b ex=%h want 0 0", o_ex_valid, dut_ex());
        end
        next_cycle();
        rst = 1'b0;
        i_ex_ready = 1'b1;
        present(I_ADD_655, 32'h604);
        #1;
        tests_run++;
        if (o_if_ready !== 1'b1 || o_rs_ren !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_busy_cleared: ready=%b ren=%b want 1 1", o_if_ready, o_rs_ren);
        end
        next_cycle();
        idle_inputs();
        #1;
        tests_run++;
        if (o_ex_valid !== 1'b1 || dut_ex() !== exp_add) begin
            tests_failed++;
            $display("FAIL rst_first_accept: got %h want %h", dut_ex(), exp_add);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        bit         busy_m [32];
        bit         m_valid;
        ex_t        m_ex;
        logic [31:0] ins;
        bit         hz, exp_ready, acc;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                7'h0F, 7'h73, 7'h00};
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
        m_valid = 1'b0;
        m_ex = '0;
        do_reset();
        next_cycle();
        for (int c = 0; c < 600; c++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 11)];
            if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom_range(0, 127));
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            i_if_valid = ($urandom_range(0, 9) < 7);
            i_if_instr = ins;
            i_if_pc    = $urandom & 32'hFFFFFFFC;
            i_ex_ready = ($urandom_range(0, 9) < 7);
            i_wb_valid = ($urandom_range(0, 9) < 4);
            i_wb_addr  = 5'($urandom_range(0, 7));
            #1;
            hz = SB_EN && i_if_valid &&
                 ((uses_rs1(ins) && busy_m[ins[19:15]]) || (uses_rs2(ins) && busy_m[ins[24:20]]));
            exp_ready = (!m_valid || i_ex_ready) && !hz;
            acc = i_if_valid && exp_ready;
            tests_run++;
            if (o_if_ready !== exp_ready || o_rs_ren !== acc ||
                o_rs1_raddr !== ins[19:15] || o_rs2_raddr !== ins[24:20]) begin
                tests_failed++;
                $display("FAIL rand_if c%0d: ready=%b ren=%b rs=%0d/%0d want %b %b %0d/%0d",
                         c, o_if_ready, o_rs_ren, o_rs1_raddr, o_rs2_raddr,
                         exp_ready, acc, ins[19:15], ins[24:20]);
            end
            tests_run++;
            if (o_ex_valid !== m_valid || (m_valid && dut_ex() !== m_ex)) begin
                tests_failed++;
                $display("FAIL rand_ex c%0d: valid=%b ex=%h want %b %h",
                         c, o_ex_valid, dut_ex(), m_valid, m_ex);
            end
            // advance the model across the coming edge
            if (SB_EN && i_wb_valid) busy_m[i_wb_addr] = 1'b0;
            if (acc) begin
                m_ex = model_decode(ins, i_if_pc);
                m_valid = 1'b1;
                if (SB_EN && m_ex.rd_we) busy_m[m_ex.rd] = 1'b1;
            end else if (i_ex_ready) begin
                m_valid = 1'b0;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_addi();
        test_branch();
        test_hazard();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I instruction decode stage. Sits directly upstream of register_file and drives its read port.
- Accepts fetched instructions on a valid/ready handshake.
- Issues rs1/rs2 read requests to the register file.
- Registers the decoded fields so they reach execute in the same cycle as the register file's 1-cycle read data.
- Holds a per-register busy scoreboard and stalls on RAW hazards.

Parameters:
XLEN, 32, datapath width; immediates are sign-extended to XLEN.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
i_if_valid  input  1  fetch has an instruction
o_if_ready  output  1  decode accepts the instruction this cycle
i_if_instr  input  32  instruction word
i_if_pc  input  XLEN  instruction PC
o_rs_ren  output  1  register file read enable
o_rs1_raddr  output  5  rs1 address (instr[19:15])
o_rs2_raddr  output  5  rs2 address (instr[24:20])
o_ex_valid  output  1  decoded instruction valid to execute
i_ex_ready  input  1  execute accepts
o_ex_pc  output  XLEN  registered PC
o_ex_opcode  output  7  instr[6:0]
o_ex_funct3  output  3  instr[14:12]
o_ex_funct7  output  7  instr[31:25]
o_ex_rd  output  5  destination register
o_ex_rd_we  output  1  instruction writes rd; 0 when rd==0
o_ex_imm  output  XLEN  sign-extended immediate
o_ex_illegal  output  1  unsupported opcode
i_wb_valid  input  1  writeback retiring a register write
i_wb_addr  input  5  register being written back

Behaviour:
Read port:
- o_rs1_raddr and o_rs2_raddr are combinational from i_if_instr.
- accept = i_if_valid && o_if_ready; o_rs_ren = accept.
- The register file holds its rdata while ren=0. Execute therefore reads rs data directly from the register file, aligned with o_ex_valid.

Handshake:
- o_if_ready = (!o_ex_valid || i_ex_ready) && !hazard.
- On accept, all o_ex_* fields are registered and o_ex_valid=1 the next cycle (latency 1).
- If the output stage empties (i_ex_ready && o_ex_valid) with no accept, o_ex_valid drops to 0.
- While o_ex_valid && !i_ex_ready, all o_ex_* outputs are held stable.

Register usage by opcode:
- rs1 used for: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- rs2 used for: BRANCH, STORE, OP.
- rd written by: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.

Immediate formats:
- I: LOAD, OP-IMM, JALR.
- S: STORE.
- B: BRANCH, bit 0 = 0.
- U: LUI, AUIPC, low 12 bits = 0.
- J: JAL, bit 0 = 0.
- All other opcodes: imm = 0.

Illegal: any opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}. The instruction still passes with o_ex_illegal=1 and o_ex_rd_we=0.

Scoreboard:
- busy[31:0]; busy[0] is hardwired 0.
- On accept with rd_we: busy[rd] is set next cycle.
- On i_wb_valid: busy[i_wb_addr] is cleared next cycle.
- Same-cycle set and clear of the same register: set wins.
- hazard = i_if_valid && ((rs1 used && busy[rs1]) || (rs2 used && busy[rs2])).
- The check uses the registered busy bits. A register cleared this cycle still stalls, because register_file writes land one cycle after the read would sample them.

Reset (asynchronous, active-high):
- o_ex_valid=0, busy=0, all o_ex_* fields=0.
- Reset mid-handshake discards the in-flight instruction.

Optional Feature:
DECODE_SCOREBOARD_EN
- Defined: scoreboard and hazard stall as above.
- Undefined: no busy array, hazard is tied to 0, o_if_ready = !o_ex_valid || i_ex_ready. Hazard avoidance becomes an external responsibility. i_wb_valid and i_wb_addr are ignored.

Test Plan:
- ADDI x5,x0,-1 (0xFFF00293) at pc 0x100, ex_ready=1 -> 1 cycle later: o_ex_valid=1, o_ex_rd=5, o_ex_rd_we=1, o_ex_imm=0xFFFFFFFF, o_ex_pc=0x100; o_rs_ren pulsed with rs1_raddr=0.
- BEQ x1,x2,-4 (0xFE208EE3) -> o_ex_imm=0xFFFFFFFC, o_ex_rd_we=0, rs1_raddr=1, rs2_raddr=2.
- ADDI x5,... followed by ADD x6,x5,x5 (scoreboard on) -> ADD stalls (o_if_ready=0, o_rs_ren=0) until the cycle after i_wb_valid with i_wb_addr=5; then accepted.
- i_ex_ready=0 for 3 cycles with o_ex_valid=1 -> all o_ex_* stable, o_if_ready=0, o_rs_ren=0.
- Opcode 0x7F -> o_ex_illegal=1, o_ex_rd_we=0, no busy bit set; rd=0 instruction (ADDI x0) sets no busy bit.
- Assert rst while o_ex_valid=1 and busy[5]=1 -> asynchronously o_ex_valid=0, busy all 0; first accept after reset release decodes normally.
